// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture block.
// Imported by camera_capture; holds the capture FSM state type.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        CAPTURE   = 2'd2,
        STOP_PEND = 2'd3
    } cap_state_t;

    localparam int CAM_DATA_W = 12;
    localparam int CAM_H_ACT  = 1280;
    localparam int CAM_V_ACT  = 960;
    localparam int CAM_X_W    = 11;
    localparam int CAM_Y_W    = 11;

endpackage

// File: rtl/camera_capture.sv
// Camera port capture: qualifies raw fval/lval/data into a pixel stream with X/Y.
// Ports: i_clk, i_rst_n, i_start, i_stop, i_fval, i_lval, i_data ->
//        o_data, o_valid, o_x, o_y, o_sof, o_frame_cnt, o_busy, o_err.
module camera_capture
    import cam_pkg::*;
#(
    parameter int DATA_W = CAM_DATA_W,
    parameter int H_ACT  = CAM_H_ACT,
    parameter int V_ACT  = CAM_V_ACT,
    parameter int X_W    = CAM_X_W,
    parameter int Y_W    = CAM_Y_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_fval,
    input  logic              i_lval,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [X_W-1:0]    o_x,
    output logic [Y_W-1:0]    o_y,
    output logic              o_sof,
    output logic [31:0]       o_frame_cnt,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [X_W-1:0] X_LIM = X_W'(H_ACT);
    localparam logic [Y_W:0]   Y_LIM = (Y_W+1)'(V_ACT);

    cap_state_t        state, state_nxt;
    logic              fv_q, lv_q, fv_p, lv_p;
    logic [DATA_W-1:0] d_q;
    logic [X_W-1:0]    x_q, x_cur;
    logic [Y_W-1:0]    y_q, y_cur;
    logic [Y_W:0]      y_end;
    logic              fv_rise, fv_fall, line_end, pix;
    logic              cap, emit, err_set, start_acc;

    always_comb begin
        fv_rise   = fv_q & ~fv_p;
        fv_fall   = fv_p & ~fv_q;
        // a line ends when it was active last cycle and is not now,
        // which also covers fval dropping while lval is still high
        line_end  = fv_p & lv_p & ~(fv_q & lv_q);
        pix       = fv_q & lv_q;
        start_acc = (state == IDLE) & i_start & ~i_stop;
        state_nxt = state;
        unique case (state)
            IDLE:      if (start_acc) state_nxt = ARM;
            ARM: begin
                if (i_stop)       state_nxt = IDLE;
                else if (fv_rise) state_nxt = CAPTURE;
            end
            CAPTURE:   if (i_stop)  state_nxt = STOP_PEND;
            STOP_PEND: if (fv_fall) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
        // the frame-start cycle in ARM already carries the first pixel
        cap   = (state == CAPTURE) | (state == STOP_PEND)
              | ((state == ARM) & fv_rise & ~i_stop);
        x_cur = fv_rise ? '0 : x_q;
        y_cur = fv_rise ? '0 : y_q;
        y_end = {1'b0, y_q} + {{Y_W{1'b0}}, line_end};
        emit  = cap & pix & (x_cur < X_LIM) & ({1'b0, y_cur} < Y_LIM);
        err_set = cap & ((pix & ~emit)
                       | (line_end & (x_q != X_LIM))
                       | (fv_fall & (y_end != Y_LIM)));
    end

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fv_q <= 1'b0;
            lv_q <= 1'b0;
            fv_p <= 1'b0;
            lv_p <= 1'b0;
            d_q  <= '0;
        end else begin
            fv_q <= i_fval;
            lv_q <= i_lval;
            fv_p <= fv_q;
            lv_p <= lv_q;
            d_q  <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            state <= state_nxt;
            // counters saturate so oversize geometry cannot alias back
            if (line_end)
                x_q <= '0;
            else if (pix)
                x_q <= (x_cur == '1) ? x_cur : x_cur + 1'b1;
            if (fv_rise)
                y_q <= '0;
            else if (line_end && y_q != '1)
                y_q <= y_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_sof       <= 1'b0;
            o_frame_cnt <= '0;
            o_err       <= 1'b0;
        end else begin
            o_valid <= emit;
            o_sof   <= emit & (x_cur == '0) & (y_cur == '0);
            if (emit) begin
                o_data <= d_q;
                o_x    <= x_cur;
                o_y    <= y_cur;
            end
            if (start_acc)
                o_err <= 1'b0;
            else if (err_set)
                o_err <= 1'b1;
            if (start_acc)
                o_frame_cnt <= '0;
            else if (cap && fv_fall)
                o_frame_cnt <= o_frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_camera_capture.sv
// Randomized bench for camera_capture with a frame-level reference model.
// Expected pixels come from generated line lengths, not from DUT internals.
module tb_camera_capture;

    localparam int DW = 12;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int XW = 4;
    localparam int YW = 3;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic          i_stop = 1'b0;
    logic          i_fval = 1'b0;
    logic          i_lval = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic [XW-1:0] o_x;
    logic [YW-1:0] o_y;
    logic          o_sof;
    logic [31:0]   o_frame_cnt;
    logic          o_busy;
    logic          o_err;

    camera_capture #(
        .DATA_W(DW), .H_ACT(H), .V_ACT(V), .X_W(XW), .Y_W(YW)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_start(i_start), .i_stop(i_stop),
        .i_fval(i_fval), .i_lval(i_lval), .i_data(i_data),
        .o_data(o_data), .o_valid(o_valid),
        .o_x(o_x), .o_y(o_y), .o_sof(o_sof),
        .o_frame_cnt(o_frame_cnt), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int sof_cyc = 0;
    int n_sof = 0;
    bit mon_en = 1'b1;
    logic [31:0] expq[$];
    bit exp_err = 1'b0;
    int exp_cnt = 0;
    int len[16];

    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en && o_valid) begin
            if (expq.size() == 0)
                chk("extra_pix", 32'(o_valid), 32'd0);
            else
                chk("pix", {12'd0, o_data, o_x, o_y, o_sof}, expq.pop_front());
            if (o_sof) begin
                n_sof++;
                chk("sof_lat", 32'(cyc - sof_cyc), 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_start = 0; i_stop = 0; i_fval = 0; i_lval = 0;
        i_rst_n = 0;
        tick(); tick();
        i_rst_n = 1;
        tick();
        expq.delete();
        exp_err = 0;
        exp_cnt = 0;
    endtask

    task automatic start_pulse();
        i_start = 1;
        tick();
        i_start = 0;
        exp_err = 0;
        exp_cnt = 0;
    endtask

    // one camera frame of nl lines with lengths len[]; cap says whether
    // the capture control should accept it; stop pulses after line sl
    task automatic send_frame(input int nl, input bit cap,
                              input int sl, input int pre);
        logic [DW-1:0] d;
        i_fval = 1;
        repeat (pre) tick();
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < len[l]; p++) begin
                d = DW'($urandom);
                i_lval = 1;
                i_data = d;
                if (l == 0 && p == 0) sof_cyc = cyc;
                if (cap && l < V && p < H)
                    expq.push_back({12'd0, d, XW'(p), YW'(l),
                                    (l == 0 && p == 0)});
                tick();
            end
            i_lval = 0;
            if (cap && (len[l] != H || l >= V)) exp_err = 1;
            for (int g = 0; g < $urandom_range(2, 4); g++) begin
                if (l == sl && g == 0) i_stop = 1;
                tick();
                i_stop = 0;
            end
            chk("err_line", 32'(o_err), 32'(exp_err));
        end
        if (cap && nl != V) exp_err = 1;
        if (cap) exp_cnt++;
        i_fval = 0;
    endtask

    task automatic clean_lens();
        for (int i = 0; i < 16; i++) len[i] = H;
    endtask

    task automatic end_checks(input string tag);
        repeat (4) tick();
        chk({tag, "_cnt"}, o_frame_cnt, 32'(exp_cnt));
        chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
        chk({tag, "_q"}, 32'(expq.size()), 32'd0);
    endtask

    initial begin
        clean_lens();
        #2;
        chk("rst_out", {o_data, o_x, o_y, o_valid, o_sof, o_busy, o_err}, 0);
        do_reset();
        chk("rst_cnt", o_frame_cnt, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);

        // two clean frames, first with fval and lval rising together
        start_pulse();
        chk("t1_busy", 32'(o_busy), 32'd1);
        n_sof = 0;
        repeat (3) tick();
        send_frame(V, 1, -1, 0);
        repeat (3) tick();
        send_frame(V, 1, -1, 2);
        end_checks("t1");
        chk("t1_sof", 32'(n_sof), 32'd2);

        // arm while a frame is already running
        do_reset();
        i_fval = 1;
        repeat (2) tick();
        start_pulse();
        send_frame(V, 0, -1, 0);
        repeat (3) tick();
        send_frame(V, 1, -1, 1);
        end_checks("t2");

        // short then long line; error sticks across a clean frame
        do_reset();
        start_pulse();
        len[0] = 6; len[1] = 10;
        send_frame(V, 1, -1, 1);
        clean_lens();
        repeat (3) tick();
        send_frame(V, 1, -1, 1);
        end_checks("t3");

        // stop in mid-frame: frame finishes, then idle
        do_reset();
        start_pulse();
        repeat (2) tick();
        send_frame(V, 1, 1, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("t4_busy_hold", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        chk("t4_busy_fall", 32'(o_busy), 32'd0);
        #1;
        send_frame(V, 0, -1, 2);
        end_checks("t4");
        chk("t4_idle", 32'(o_busy), 32'd0);

        // start and stop together while armed
        do_reset();
        start_pulse();
        chk("t5_arm", 32'(o_busy), 32'd1);
        i_start = 1; i_stop = 1;
        tick();
        i_start = 0; i_stop = 0;
        chk("t5_both", 32'(o_busy), 32'd0);

        // asynchronous reset in the middle of a captured line
        start_pulse();
        mon_en = 0;
        i_fval = 1;
        i_lval = 1;
        repeat (5) begin
            i_data = DW'($urandom);
            tick();
        end
        #2 i_rst_n = 0;
        #1;
        chk("t5_rst_out", {o_data, o_x, o_y, o_valid, o_sof, o_busy, o_err}, 0);
        chk("t5_rst_cnt", o_frame_cnt, 32'd0);
        expq.delete();
        exp_cnt = 0;
        exp_err = 0;
        mon_en = 1;
        tick();
        i_rst_n = 1;
        repeat (3) tick();
        start_pulse();
        repeat (4) tick();
        i_lval = 0;
        tick();
        i_fval = 0;
        repeat (3) tick();
        chk("t5_no_cap", 32'(expq.size()), 32'd0);
        send_frame(V, 1, -1, 1);
        end_checks("t5");

        // random geometry frames
        do_reset();
        start_pulse();
        for (int f = 0; f < 6; f++) begin
            int nl;
            nl = $urandom_range(V - 1, V + 1);
            for (int i = 0; i < nl; i++)
                len[i] = (($urandom_range(0, 2) == 0) ?
                          $urandom_range(H - 1, H + 1) : H);
            repeat ($urandom_range(2, 5)) tick();
            send_frame(nl, 1, -1, $urandom_range(0, 2));
        end
        end_checks("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
